// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: byte-lane writes, registered read with valid strobe, self-clear after reset.
// Optional macro DPRAM_WR_BYPASS_EN selects write-first collisions; default build is read-first.
module dual_port_ram #(
   parameter int unsigned MEM_DEPTH  = 128,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [BE_WIDTH-1:0]   wr_be_i,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  init_done_o
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  wr_acc, rd_acc;
   logic                  wr_in_range, rd_in_range;
   logic [DATA_WIDTH-1:0] rd_word;

   assign wr_acc      = wr_valid_i && ready_q;
   assign rd_acc      = rd_valid_i && ready_q;
   // Only reachable when MEM_DEPTH is not a power of two.
   assign wr_in_range = {1'b0, wr_addr_i} < DepthW;
   assign rd_in_range = {1'b0, rd_addr_i} < DepthW;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      ready_d    = ready_q;
      unique case (state_q)
         StInit: begin
            if (init_cnt_q == LastAddr) begin
               state_d = StRun;
               ready_d = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         StRun: begin
            ready_d = 1'b1;
         end
      endcase
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem_q[rd_addr_i];
`ifdef DPRAM_WR_BYPASS_EN
         // Write-first: enabled lanes of a same-address write override the stored word.
         if (wr_acc && (wr_addr_i == rd_addr_i)) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
               if (wr_be_i[k]) rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
            end
         end
`endif
      end
      rd_data_d  = rd_acc ? rd_word : rd_data_q;
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         ready_q    <= ready_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage has no reset; the INIT sweep clears it after every reset release.
   always_ff @(posedge clk_i) begin
      if (state_q == StInit) begin
         mem_q[init_cnt_q] <= '0;
      end else if (wr_acc && wr_in_range) begin
         for (int k = 0; k < BE_WIDTH; k++) begin
            if (wr_be_i[k]) mem_q[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
         end
      end
   end

   assign wr_ready_o  = ready_q;
   assign rd_ready_o  = ready_q;
   assign init_done_o = ready_q;
   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;

endmodule
